// File: rtl/maclaurin_pkg.sv
// Shared types and Q3.28 coefficient tables for the Maclaurin series evaluator.
package maclaurin_pkg;

   typedef enum logic [1:0] {
      MODE_LN   = 2'd0,
      MODE_EXP  = 2'd1,
      MODE_SIN  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      StUncfg,
      StIdle,
      StCalc,
      StDone,
      StErr
   } state_e;

   // Fractional bits of the master coefficient tables
   localparam int unsigned COEF_FRAC = 28;

   typedef logic signed [31:0] coef_t;

   // ln(1+x): (-1)^(k+1)/k, rounded to nearest in Q3.28
   localparam coef_t COEF_LN [0:15] = '{
      32'sd0,          32'sd268435456, -32'sd134217728, 32'sd89478485,
      -32'sd67108864,  32'sd53687091,  -32'sd44739243,  32'sd38347922,
      -32'sd33554432,  32'sd29826162,  -32'sd26843546,  32'sd24403223,
      -32'sd22369621,  32'sd20648881,  -32'sd19173961,  32'sd17895697
   };

   // exp(x): 1/k!, rounded to nearest in Q3.28
   localparam coef_t COEF_EXP [0:15] = '{
      32'sd268435456,  32'sd268435456, 32'sd134217728,  32'sd44739243,
      32'sd11184811,   32'sd2236962,   32'sd372827,     32'sd53261,
      32'sd6658,       32'sd740,       32'sd74,         32'sd7,
      32'sd1,          32'sd0,         32'sd0,          32'sd0
   };

   // sin(x): odd terms only, alternating sign
   localparam coef_t COEF_SIN [0:15] = '{
      32'sd0,          32'sd268435456, 32'sd0,          -32'sd44739243,
      32'sd0,          32'sd2236962,   32'sd0,          -32'sd53261,
      32'sd0,          32'sd740,       32'sd0,          -32'sd7,
      32'sd0,          32'sd0,         32'sd0,          32'sd0
   };

endpackage

// File: rtl/maclaurin_coef_rom.sv
// Combinational coefficient lookup, rounded from Q3.28 down to CF fractional bits.
module maclaurin_coef_rom
   import maclaurin_pkg::*;
#(
   parameter int unsigned OW = 32,
   parameter int unsigned CF = 14
) (
   input  mode_e                i_mode,
   input  logic [3:0]           i_index,
   output logic signed [OW-1:0] o_coef
);

   localparam int unsigned RSH = COEF_FRAC - CF;
   // Half an output LSB; zero when no shift is needed
   localparam logic signed [63:0] RND = (64'sd1 <<< RSH) >>> 1;

   logic signed [31:0] w_raw;

   // Select the raw table entry for the configured function
   always_comb begin
      w_raw = '0;
      case (i_mode)
         MODE_LN:  w_raw = COEF_LN[i_index];
         MODE_EXP: w_raw = COEF_EXP[i_index];
         MODE_SIN: w_raw = COEF_SIN[i_index];
         default:  w_raw = '0;
      endcase
   end

   // Round to nearest (ties up) by adding half an LSB before the arithmetic shift
   assign o_coef = OW'((64'(w_raw) + RND) >>> RSH);

endmodule

// File: rtl/maclaurin_eval.sv
// Streaming Horner-rule evaluator of a truncated Maclaurin series, one multiply-add per clock,
// with saturating accumulator and sticky per-sample overflow.
module maclaurin_eval
   import maclaurin_pkg::*;
#(
   parameter int unsigned XW        = 8,
   parameter int unsigned XF        = 6,
   parameter int unsigned OW        = 32,
   parameter int unsigned CF        = 14,
   parameter int unsigned MAX_TERMS = 7,
   parameter int unsigned NW        = $clog2(MAX_TERMS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NW-1:0]        N,
   input  logic [1:0]           mode,
   input  logic                 in_valid,
   input  logic signed [XW-1:0] X,
   output logic                 ready,
   output logic signed [OW-1:0] Y,
   output logic                 valid,
   output logic                 overflow,
   output logic                 error
);

   localparam int unsigned PW = OW + XW;
   localparam logic signed [PW-1:0] SAT_MAX = {{(XW + 1){1'b0}}, {(OW - 1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(XW + 1){1'b1}}, {(OW - 1){1'b0}}};

   state_e               r_state;
   mode_e                r_mode;
   logic [NW-1:0]        r_n;
   logic [NW-1:0]        r_k;
   logic signed [OW-1:0] r_acc;
   logic signed [XW-1:0] r_x;
   logic                 r_ovf;
   logic                 r_ready;
   logic                 r_valid;
   logic                 r_overflow;
   logic                 r_error;
   logic signed [OW-1:0] r_y;

   logic                 w_cfg_bad;
   logic [3:0]           w_idx;
   logic signed [OW-1:0] w_coef;
   logic signed [PW-1:0] w_acc_ext;
   logic signed [PW-1:0] w_x_ext;
   logic signed [PW-1:0] w_coef_ext;
   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] w_sum;
   logic                 w_clip_hi;
   logic                 w_clip_lo;
   logic                 w_clip;
   logic signed [OW-1:0] w_sat;

   assign w_cfg_bad = (N == '0) || (32'(N) > MAX_TERMS) || (mode == 2'd3);

   // Accept needs c[N]; each CALC step needs c[k]
   assign w_idx = (r_state == StCalc) ? 4'(r_k) : 4'(r_n);

   maclaurin_coef_rom #(
      .OW (OW),
      .CF (CF)
   ) u_coef_rom (
      .i_mode  (r_mode),
      .i_index (w_idx),
      .o_coef  (w_coef)
   );

   // One Horner step: floor((acc*x) >> XF) + c[k], clipped to the OW signed range
   assign w_acc_ext  = PW'(r_acc);
   assign w_x_ext    = PW'(r_x);
   assign w_coef_ext = PW'(w_coef);
   assign w_prod     = w_acc_ext * w_x_ext;
   assign w_sum      = (w_prod >>> XF) + w_coef_ext;
   assign w_clip_hi  = w_sum > SAT_MAX;
   assign w_clip_lo  = w_sum < SAT_MIN;
   assign w_clip     = w_clip_hi | w_clip_lo;
   assign w_sat      = w_clip_hi ? SAT_MAX[OW-1:0] :
                       w_clip_lo ? SAT_MIN[OW-1:0] : w_sum[OW-1:0];

   // Control FSM, datapath registers and registered outputs; start overrides every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StUncfg;
         r_mode     <= MODE_LN;
         r_n        <= '0;
         r_k        <= '0;
         r_acc      <= '0;
         r_x        <= '0;
         r_ovf      <= 1'b0;
         r_ready    <= 1'b0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
         r_error    <= 1'b0;
         r_y        <= '0;
      end else begin
         r_valid <= 1'b0;
         if (start) begin
            // Aborts any sample in flight and drops a same-cycle X
            r_n    <= N;
            r_mode <= mode_e'(mode);
            if (w_cfg_bad) begin
               r_state <= StErr;
               r_ready <= 1'b0;
               r_error <= 1'b1;
            end else begin
               r_state <= StIdle;
               r_ready <= 1'b1;
               r_error <= 1'b0;
            end
         end else begin
            case (r_state)
               StIdle, StDone: begin
                  if (in_valid) begin
                     r_acc   <= w_coef;
                     r_x     <= X;
                     r_k     <= r_n - NW'(1);
                     r_ovf   <= 1'b0;
                     r_state <= StCalc;
                     r_ready <= 1'b0;
                  end else begin
                     r_state <= StIdle;
                     r_ready <= 1'b1;
                  end
               end
               StCalc: begin
                  r_acc <= w_sat;
                  r_ovf <= r_ovf | w_clip;
                  if (r_k == '0) begin
                     r_state    <= StDone;
                     r_ready    <= 1'b1;
                     r_valid    <= 1'b1;
                     r_y        <= w_sat;
                     r_overflow <= r_ovf | w_clip;
                  end else begin
                     r_k <= r_k - NW'(1);
                  end
               end
               default: ;  // StUncfg and StErr only leave on start
            endcase
         end
      end
   end

   assign ready    = r_ready;
   assign valid    = r_valid;
   assign overflow = r_overflow;
   assign error    = r_error;
   assign Y        = r_y;

endmodule

// File: tb/tb_maclaurin_eval.sv
// Directed bench for maclaurin_eval: default-width instance plus an OW=16 instance for saturation.
module tb_maclaurin_eval;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic in_valid;
   logic [2:0] n_cfg;
   logic [1:0] mode;
   logic signed [7:0] x;

   logic ready, valid, overflow, error;
   logic signed [31:0] y;
   logic ready16, valid16, overflow16, error16;
   logic signed [15:0] y16;

   int checks = 0;
   int errors = 0;
   int lat;
   int cnt;
   int first;

   always #5 clk = ~clk;

   maclaurin_eval dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .N        (n_cfg),
      .mode     (mode),
      .in_valid (in_valid),
      .X        (x),
      .ready    (ready),
      .Y        (y),
      .valid    (valid),
      .overflow (overflow),
      .error    (error)
   );

   maclaurin_eval #(.OW(16)) dut16 (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .N        (n_cfg),
      .mode     (mode),
      .in_valid (in_valid),
      .X        (x),
      .ready    (ready16),
      .Y        (y16),
      .valid    (valid16),
      .overflow (overflow16),
      .error    (error16)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic configure(input logic [1:0] m, input logic [2:0] n);
      start = 1'b1;
      mode  = m;
      n_cfg = n;
      cyc();
      start = 1'b0;
   endtask

   task automatic send(input logic signed [7:0] xv);
      in_valid = 1'b1;
      x        = xv;
      cyc();
      in_valid = 1'b0;
   endtask

   // Cycle index of valid after the accept edge; 1 is the cycle right after that edge
   task automatic wait_valid(input bit use16, output int l);
      l = 1;
      while (!(use16 ? valid16 : valid) && l < 30) begin
         cyc();
         l++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; mode = 2'd0; n_cfg = 3'd0; x = 8'sd0;
      cyc();
      cyc();
      chk("rst_ready", ready, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", error, 0);
      chk("rst_y", y, 0);
      chk("rst_ready16", ready16, 0);
      rst = 1'b0;

      // Unconfigured: samples ignored, ready low
      in_valid = 1'b1; x = 8'sd32; cnt = 0;
      repeat (4) begin
         cyc();
         if (valid || ready) cnt++;
      end
      in_valid = 1'b0;
      chk("uncfg_idle", cnt, 0);

      // exp(0.5), N=2
      configure(2'd1, 3'd2);
      chk("cfg_ready", ready, 1);
      chk("cfg_err", error, 0);
      send(8'sd32);
      wait_valid(1'b0, lat);
      chk("exp_lat", lat, 3);
      chk("exp_y", y, 26624);
      chk("exp_ovf", overflow, 0);
      chk("done_ready", ready, 1);
      cyc();
      chk("valid_pulse", valid, 0);
      chk("y_hold", y, 26624);

      // ln(1.5), N=3
      configure(2'd0, 3'd3);
      send(8'sd32);
      wait_valid(1'b0, lat);
      chk("ln_lat", lat, 4);
      chk("ln_y", y, 6826);

      // sin(0.5), N=3
      configure(2'd2, 3'd3);
      send(8'sd32);
      wait_valid(1'b0, lat);
      chk("sin_lat", lat, 4);
      chk("sin_y", y, 7850);

      // Back-to-back: in_valid held high, one accept every N+1 cycles
      configure(2'd1, 3'd2);
      in_valid = 1'b1; x = 8'sd32; cnt = 0; first = 0;
      for (int i = 1; i <= 60; i++) begin
         cyc();
         if (valid) begin
            cnt++;
            if (first == 0) first = i;
            chk("b2b_y", y, 26624);
         end
      end
      in_valid = 1'b0;
      chk("b2b_count", cnt, 20);
      chk("b2b_first", first, 3);

      // Gaps: ready stays high, no spurious valid
      cnt = 0;
      repeat (6) begin
         cyc();
         if (valid || !ready) cnt++;
      end
      chk("gap_idle", cnt, 0);
      send(8'sd0);
      wait_valid(1'b0, lat);
      chk("gap_lat", lat, 3);
      chk("gap_y", y, 16384);
      cnt = 0;
      repeat (6) begin
         cyc();
         if (valid) cnt++;
      end
      chk("gap_single", cnt, 0);

      // Saturation on the 16-bit instance, then a clean sample accepted in the DONE cycle
      configure(2'd1, 3'd7);
      send(8'sd127);
      wait_valid(1'b1, lat);
      chk("ovf_lat", lat, 8);
      chk("ovf_y", y16, 32767);
      chk("ovf_flag", overflow16, 1);
      send(8'sd0);
      wait_valid(1'b1, lat);
      chk("ovf_clr_lat", lat, 8);
      chk("ovf_clr_y", y16, 16384);
      chk("ovf_clr_flag", overflow16, 0);

      // Configuration errors
      configure(2'd1, 3'd0);
      chk("err_n0", error, 1);
      chk("err_n0_ready", ready, 0);
      chk("err_n0_16", error16, 1);
      in_valid = 1'b1; x = 8'sd32; cnt = 0;
      repeat (5) begin
         cyc();
         if (valid || ready || !error) cnt++;
      end
      in_valid = 1'b0;
      chk("err_hold", cnt, 0);
      configure(2'd1, 3'd2);
      chk("err_clear", error, 0);
      chk("err_clear_ready", ready, 1);
      configure(2'd3, 3'd2);
      chk("err_mode3", error, 1);
      chk("err_mode3_ready", ready, 0);
      configure(2'd1, 3'd2);

      // Abort: start mid-CALC with a same-cycle X, both discarded
      send(8'sd32);
      start = 1'b1; mode = 2'd0; n_cfg = 3'd3; in_valid = 1'b1; x = 8'sd32;
      cyc();
      start = 1'b0; in_valid = 1'b0;
      chk("abort_ready", ready, 1);
      cnt = 0;
      repeat (6) begin
         cyc();
         if (valid) cnt++;
      end
      chk("abort_novalid", cnt, 0);
      send(8'sd32);
      wait_valid(1'b0, lat);
      chk("abort_new_lat", lat, 4);
      chk("abort_new_y", y, 6826);

      // Reset mid-CALC: outputs clear immediately, configuration lost
      cyc();
      send(8'sd32);
      cyc();
      rst = 1'b1;
      #1;
      chk("arst_ready", ready, 0);
      chk("arst_valid", valid, 0);
      chk("arst_y", y, 0);
      chk("arst_err", error, 0);
      chk("arst_ovf", overflow, 0);
      cyc();
      rst = 1'b0;
      in_valid = 1'b1; x = 8'sd32; cnt = 0;
      repeat (5) begin
         cyc();
         if (ready || valid) cnt++;
      end
      in_valid = 1'b0;
      chk("arst_uncfg", cnt, 0);
      configure(2'd1, 3'd2);
      chk("arst_recfg", ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
